cw_decoder_ingress: RTL

CW_DECODER_INGRESS -- requirements
Module: cw_decoder_ingress

---
 rtl/cw_decoder_ingress_if.sv | 38 +++
 rtl/cw_decoder_ingress.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cw_decoder_ingress_if.sv
// Signal bundle between the codeword writer, the decode core and the message sink.
interface cw_decoder_ingress_if #(
    parameter int CW_W  = 18,
    parameter int DEPTH = 16,
    parameter int BIN_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             start;
    logic [CW_W-1:0]  cw_in;
    logic             wr_en;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] data_count;
    logic             overflow;
    logic [CW_W-1:0]  core_cw_word;
    logic             core_fifoempty;
    logic             core_readfifo;
    logic             core_bit;
    logic             core_bit_vld;
    logic             core_done;
    logic [BIN_W-1:0] msg_word;
    logic             msg_word_vld;
    logic             msg_last;
    logic             msg_done;

    modport slave (
        input  start, cw_in, wr_en, core_readfifo, core_bit, core_bit_vld, core_done,
        output full, empty, data_count, overflow, core_cw_word, core_fifoempty,
               msg_word, msg_word_vld, msg_last, msg_done
    );

    modport master (
        output start, cw_in, wr_en, core_readfifo, core_bit, core_bit_vld, core_done,
        input  full, empty, data_count, overflow, core_cw_word, core_fifoempty,
               msg_word, msg_word_vld, msg_last, msg_done
    );
endinterface

// File: rtl/cw_decoder_ingress.sv
// Codeword FIFO, message sequencer and serial-to-byte packer in front of a CW decode core.
// Define CW_FIFO_FWFT_EN for a first-word-fall-through head word; default is registered read.
//
// state | meaning
// IDLE  | FIFO hidden from core, waiting for start
// RUN   | core pops codewords until WORDS_PER_MSG have been taken
// DRAIN | FIFO hidden again, waiting for core_done
// DONE  | one cycle: msg_done, trailing word flushed
module cw_decoder_ingress #(
    parameter int CW_W          = 18,
    parameter int DEPTH         = 16,
    parameter int WORDS_PER_MSG = 10,
    parameter int BIN_W         = 8
) (
    input  logic                clk,
    input  logic                rst_b,
    cw_decoder_ingress_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = $clog2(WORDS_PER_MSG + 1);
    localparam int BC_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q, overflow_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             full, empty, fifoempty, push, pop, flush;

    logic [BIN_W-1:0] pack_q, pack_d, pack_in;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic [BIN_W-1:0] word_q, word_d;
    logic             vld_q, vld_d, last_q, last_d, word_cmpl;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign fifoempty = (state_q == RUN) ? empty : 1'b1;
    // A full FIFO drops the write even when a pop frees a slot in the same cycle.
    assign push      = bus.wr_en & ~full;
    assign pop       = bus.core_readfifo & ~fifoempty;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        overflow_d = overflow_q;
        flush      = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d    = RUN;
                wcnt_d     = '0;
                overflow_d = 1'b0;
            end
            RUN: if (pop) begin
                wcnt_d = wcnt_q + WC_W'(1);
                if (wcnt_d == WC_W'(WORDS_PER_MSG)) state_d = DRAIN;
            end
            DRAIN: if (bus.core_done) begin
                state_d = DONE;
                flush   = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.wr_en && full) overflow_d = 1'b1;
    end

    // The bit arriving with the flush is packed first; an empty pack emits a zero word.
    always_comb begin
        pack_in = pack_q;
        if (bus.core_bit_vld) pack_in[bcnt_q] = bus.core_bit;
        word_cmpl = bus.core_bit_vld && (bcnt_q == BC_W'(BIN_W - 1));
        pack_d = pack_in;
        bcnt_d = bus.core_bit_vld ? bcnt_q + BC_W'(1) : bcnt_q;
        word_d = word_q;
        vld_d  = 1'b0;
        last_d = 1'b0;
        if (word_cmpl || flush) begin
            word_d = pack_in;
            vld_d  = 1'b1;
            last_d = flush;
            pack_d = '0;
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.cw_in;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wcnt_q     <= '0;
            pack_q     <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            wcnt_q     <= wcnt_d;
            pack_q     <= pack_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CW_FIFO_FWFT_EN
    assign bus.core_cw_word = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [CW_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)   rdata_q <= '0;
        else if (pop) rdata_q <= mem_q[rd_ptr_q];
    end

    assign bus.core_cw_word = rdata_q;
`endif

    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.data_count     = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.core_fifoempty = fifoempty;
    assign bus.msg_word       = word_q;
    assign bus.msg_word_vld   = vld_q;
    assign bus.msg_last       = last_q;
    assign bus.msg_done       = (state_q == DONE);
endmodule
